// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame size and timing helper.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACKWAIT, FAIL} tx_state_t;

  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned us2cyc(input int unsigned clk_hz, input int unsigned us);
    return 32'((64'(clk_hz) * 64'(us)) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample glitch filter for one PS/2 line.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // level follows sync[1] only after FILTER_LEN consecutive differing samples;
  // fall is registered alongside the level change so it adds no extra cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          fall  <= level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, ack check.
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 24_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15_000,
  parameter int unsigned XFER_TIMEOUT_US  = 2_000,
  parameter int unsigned FILTER_LEN       = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       clk_oe,
  output logic       dat_oe
);

  localparam int unsigned INH_CYC   = us2cyc(CLK_HZ, INHIBIT_US);
  localparam int unsigned START_CYC = us2cyc(CLK_HZ, START_TIMEOUT_US);
  localparam int unsigned XFER_CYC  = us2cyc(CLK_HZ, XFER_TIMEOUT_US);
  localparam int unsigned TW        = $clog2(START_CYC) + 1;

  localparam logic [TW-1:0] INH_LAST   = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_CYC - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_CYC - 1);

  tx_state_t     state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [9:0]    frame, frame_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic          dat_bit, dat_bit_n;

  logic clk_f, clk_fall, dat_f, dat_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_clk_i),
    .level   (clk_f),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_dat_i),
    .level   (dat_f),
    .fall    (dat_fall_unused)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      frame   <= '0;
      bitcnt  <= '0;
      dat_bit <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      frame   <= frame_n;
      bitcnt  <= bitcnt_n;
      dat_bit <= dat_bit_n;
    end
  end

  // The frame shifts right on every device fall, so frame[0] is always the next bit to drive.
  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bitcnt_n  = bitcnt;
    dat_bit_n = dat_bit;
    timer_n   = (timer == '1) ? timer : timer + 1'b1;

    case (state)
      IDLE: begin
        timer_n  = '0;
        bitcnt_n = '0;
        if (tx_valid) begin
          frame_n = {1'b1, ~^tx_data, tx_data};
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer == INH_LAST) begin
          timer_n  = '0;
          bitcnt_n = '0;
          state_n  = RTS;
        end
      end
      RTS: begin
        if (clk_fall) begin
          dat_bit_n = frame[0];
          frame_n   = {1'b1, frame[9:1]};
          bitcnt_n  = 4'd1;
          timer_n   = '0;
          state_n   = SHIFT;
        end else if (timer >= START_LAST) begin
          state_n = FAIL;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          if (bitcnt == 4'(FRAME_BITS)) begin
            state_n = dat_f ? FAIL : ACKWAIT;
          end else begin
            dat_bit_n = frame[0];
            frame_n   = {1'b1, frame[9:1]};
            bitcnt_n  = bitcnt + 4'd1;
          end
        end else if (timer >= XFER_LAST) begin
          state_n = FAIL;
        end
      end
      ACKWAIT: begin
        if (clk_f && dat_f) begin
          state_n = IDLE;
        end else if (timer >= XFER_LAST) begin
          state_n = FAIL;
        end
      end
      FAIL: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE) && !reset;
    busy     = (state != IDLE);
    clk_oe   = (state == INHIBIT);
    dat_oe   = (state == RTS) || ((state == SHIFT) && !dat_bit);
    tx_done  = (state == ACKWAIT) && clk_f && dat_f && !reset;
    tx_error = (state == FAIL) && !reset;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard on the shared open-collector PS/2 lines, for example 0xED set-LEDs followed by its LED mask, or 0xFF reset.
- It is the counterpart of the existing device-to-host PS/2 keyboard receiver. It sits beside that receiver in the top level.
- The top level resolves the lines as: ps2_clk_io = clk_oe ? 0 : Z, and ps2_data_io = dat_oe ? 0 : Z.
- busy gates the receiver so it ignores the line during a host transmission.

Parameters:
- CLK_HZ, 24000000: clk_sys frequency in Hz. All timers are derived from it.
- INHIBIT_US, 100: how long clk is held low before request-to-send.
- START_TIMEOUT_US, 15000: maximum wait from clk release to the first device falling edge.
- XFER_TIMEOUT_US, 2000: maximum time from the first falling edge to the ack edge.
- FILTER_LEN, 4: number of consecutive equal samples needed to accept a line level change.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: send request. Accepted only when tx_ready=1.
- tx_ready, out, 1: high in IDLE.
- tx_done, out, 1: one-cycle pulse when the device has acked.
- tx_error, out, 1: one-cycle pulse on timeout or missing ack.
- busy, out, 1: high in every state except IDLE.
- ps2_clk_i, in, 1: raw PS/2 clock line level. Asynchronous.
- ps2_dat_i, in, 1: raw PS/2 data line level. Asynchronous.
- clk_oe, out, 1: 1 drives the PS/2 clock low.
- dat_oe, out, 1: 1 drives the PS/2 data low.

Behaviour:
- Reset values: tx_ready=0 during reset and 1 from the first cycle after reset. tx_done=0, tx_error=0, busy=0, clk_oe=0, dat_oe=0. State is IDLE and all counters are 0.
- Reset taken mid-transfer releases both lines on the next clk_sys edge. No done or error pulse is generated.
- Input conditioning: each raw line passes through a 2-flop synchronizer and then a FILTER_LEN-sample glitch filter. fall = filtered clk transitions 1→0, registered. Total latency from raw input to fall is 2+FILTER_LEN cycles.
- Shift register: on accept, load a 10-bit frame: {stop=1, parity=~^tx_data (odd parity), tx_data}.
- State IDLE:
  - clk_oe=0, dat_oe=0, tx_ready=1.
  - tx_valid=1 latches tx_data, clears the timer and goes to INHIBIT.
- State INHIBIT:
  - clk_oe=1.
  - After INHIBIT_US*CLK_HZ/1e6 cycles, set dat_oe=1 (start bit) and go to RTS.
- State RTS:
  - dat_oe=1, clk_oe=0 (clock released). Timer and bit count are cleared on entry.
  - On the first fall: drive frame[0] (dat_oe = ~bit), set bitcnt=1 and go to SHIFT.
  - If the timer reaches START_TIMEOUT, go to FAIL.
- State SHIFT:
  - On each fall with bitcnt 1..9: drive frame[bitcnt] and increment bitcnt.
  - bitcnt=9 drives the stop bit, which means dat_oe=0 (line released).
  - On the fall with bitcnt=10: sample filtered data.
    - Data 0 → ACKWAIT.
    - Data 1 → FAIL (no ack).
  - Timer reaching XFER_TIMEOUT → FAIL.
- State ACKWAIT:
  - Wait until filtered clk=1 and data=1, then pulse tx_done and go to IDLE.
  - XFER_TIMEOUT is still enforced here; expiry → FAIL.
- State FAIL: release both lines, pulse tx_error for one cycle, go to IDLE.
- Timer:
  - Free-running while busy.
  - Width is ceil(log2(START_TIMEOUT cycles))+1.
  - Saturates; it never wraps.
- tx_valid outside IDLE is ignored. It is not queued.
- tx_done and tx_error are never high in the same cycle.
- A device-initiated clock edge in IDLE has no effect on this block.

Decomposition:
- Shared package ps2_pkg:
  - tx_state_t enum: IDLE, INHIBIT, RTS, SHIFT, ACKWAIT, FAIL.
  - Function us2cyc(CLK_HZ, us).
  - Constant FRAME_BITS=10.
- Sub-module ps2_line_filter (synchronizer plus glitch filter, parameter FILTER_LEN). Instantiated twice, for clk and data. The receiver can reuse it later.

Test Plan:
- Send 0xED with a behavioural device model clocking at 12 kHz and acking. Required:
  - clk held low for 100 µs ±1 cycle.
  - Device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity=1, stop=1.
  - Exactly one tx_done pulse, and both oe signals are 0 afterwards.
- Send 0x07 and then 0x00 back-to-back (tx_valid is asserted again on the cycle after tx_done). Required: parity 0 for 0x07, parity 1 for 0x00, and both bytes are acked.
- No device present (ps2_clk_i stuck at 1). Required: tx_error pulses 100 µs + 15 ms after accept, and the lines are released.
- Device clocks all 11 edges but does not pull data low on the 11th. Required: tx_error, no tx_done.
- Assert reset after the 4th falling edge. Required: clk_oe=0 and dat_oe=0 on the next cycle, no pulses, and tx_ready=1 from the first cycle after reset.
- Inject 2-cycle glitches on ps2_clk_i during SHIFT, and pulse tx_valid while busy. Required: bit count is unaffected, the byte is received correctly, and the second tx_valid is ignored (only one frame on the wire).
